// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive path so the receiver, the RX FIFO and
// the consumer agree on byte width and buffer depth.
package uart_rx_fifo_pkg;

    localparam int RX_DATA_W     = 8;
    localparam int RX_ADDR_W     = 4;
    localparam int RX_FIFO_DEPTH = 1 << RX_ADDR_W;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/uart_fifo_regfile.sv
// 1-write / 1-async-read register array; storage is never reset, so contents
// are meaningful only where the owning FIFO says so.
module uart_fifo_regfile
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_W = RX_DATA_W,
    parameter int ADDR_W = RX_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [fifo_depth(ADDR_W)];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: first-word-fall-through
// read port, occupancy count and a sticky overflow flag.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_W = RX_DATA_W,
    parameter int ADDR_W = RX_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              rd,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(fifo_depth(ADDR_W));

    logic [ADDR_W-1:0] w_ptr;
    logic [ADDR_W-1:0] r_ptr;
    logic              do_wr;
    logic              do_rd;
    logic              drop_wr;

    // Strobe semantics: wr and rd are single-cycle strobes with no back-pressure.
    // A wr is accepted unless the FIFO is full and no rd frees a slot in the
    // same cycle; a rd is honoured whenever the FIFO is non-empty.
    assign do_rd   = rd && !empty;
    assign do_wr   = wr && (!full || rd);
    assign drop_wr = wr && full && !rd;

    // Flags decode from the count register only, so they never see rd/wr.
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    uart_fifo_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .we    (do_wr),
        .waddr (w_ptr),
        .wdata (w_data),
        .raddr (r_ptr),
        .rdata (r_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (do_rd) begin
                r_ptr <= r_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A dropped write takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop_wr) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: reset, single byte, fill/overflow/wrap,
// simultaneous read+write at full and empty, and asynchronous mid-stream reset.
module tb_uart_rx_fifo;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk;
    logic          reset;
    logic          wr;
    logic [DW-1:0] w_data;
    logic          rd;
    logic          clr_ovf;
    logic [DW-1:0] r_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;

    int checks;
    int failures;
    logic [DW-1:0] exp_q[$];

    uart_rx_fifo #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .w_data   (w_data),
        .rd       (rd),
        .clr_ovf  (clr_ovf),
        .r_data   (r_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] b);
        wr     = 1'b1;
        w_data = b;
        tick();
        wr     = 1'b0;
    endtask

    task automatic pop();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic push_pop(input logic [DW-1:0] b);
        wr     = 1'b1;
        rd     = 1'b1;
        w_data = b;
        tick();
        wr     = 1'b0;
        rd     = 1'b0;
    endtask

    task automatic drain_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, {24'd0, r_data}, {24'd0, exp_q.pop_front()});
            pop();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        wr       = 1'b0;
        rd       = 1'b0;
        clr_ovf  = 1'b0;
        w_data   = '0;

        // Reset then idle
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        pop();
        pop();
        check("idle_rd_count", {27'd0, count}, 32'd0);
        check("idle_rd_empty", {31'd0, empty}, 32'd1);

        // Single byte
        push(8'h55);
        check("single_data", {24'd0, r_data}, 32'h55);
        check("single_empty", {31'd0, empty}, 32'd0);
        check("single_count", {27'd0, count}, 32'd1);
        pop();
        check("single_pop_empty", {31'd0, empty}, 32'd1);
        check("single_pop_count", {27'd0, count}, 32'd0);

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            exp_q.push_back(8'(i));
        end
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_count", {27'd0, count}, 32'd16);
        check("fill_ovf_clear", {31'd0, overflow}, 32'd0);
        push(8'hAA);
        check("drop_ovf", {31'd0, overflow}, 32'd1);
        check("drop_count", {27'd0, count}, 32'd16);
        drain_check("fill_drain", 16);
        check("drain_empty", {31'd0, empty}, 32'd1);
        check("drain_full", {31'd0, full}, 32'd0);

        // Wrap-around
        for (int i = 0; i < 4; i++) begin
            push(8'(8'h10 + i));
            exp_q.push_back(8'(8'h10 + i));
        end
        check("wrap_count", {27'd0, count}, 32'd4);
        drain_check("wrap_drain", 4);

        // Overflow clear
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_ovf", {31'd0, overflow}, 32'd0);

        // Simultaneous read+write at full
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h20 + i));
        end
        for (int i = 1; i < 16; i++) begin
            exp_q.push_back(8'(8'h20 + i));
        end
        exp_q.push_back(8'h77);
        push_pop(8'h77);
        check("full_rw_count", {27'd0, count}, 32'd16);
        check("full_rw_ovf", {31'd0, overflow}, 32'd0);
        check("full_rw_full", {31'd0, full}, 32'd1);
        drain_check("full_rw_drain", 16);
        check("full_rw_empty", {31'd0, empty}, 32'd1);

        // Simultaneous read+write at empty
        push_pop(8'h3C);
        check("empty_rw_count", {27'd0, count}, 32'd1);
        check("empty_rw_data", {24'd0, r_data}, 32'h3C);
        pop();

        // Dropped write and clear in the same cycle: set wins
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h40 + i));
        end
        clr_ovf = 1'b1;
        push(8'hEE);
        clr_ovf = 1'b0;
        check("clr_vs_drop_ovf", {31'd0, overflow}, 32'd1);
        check("clr_vs_drop_count", {27'd0, count}, 32'd16);
        check("clr_vs_drop_head", {24'd0, r_data}, 32'h40);

        // Asynchronous reset mid-stream
        repeat (11) pop();
        check("pre_rst_count", {27'd0, count}, 32'd5);
        check("pre_rst_head", {24'd0, r_data}, 32'h4B);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_empty", {31'd0, empty}, 32'd1);
        check("async_rst_count", {27'd0, count}, 32'd0);
        check("async_rst_ovf", {31'd0, overflow}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        push(8'h81);
        check("post_rst_data", {24'd0, r_data}, 32'h81);
        check("post_rst_count", {27'd0, count}, 32'd1);
        pop();
        check("post_rst_empty", {31'd0, empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
